// File: rtl/apb_requester.sv
// APB4 initiator: turns single-beat valid/ready commands into
// SETUP/ACCESS transfers and reports each completion on a one-cycle pulse.
//
// Ports:
//   clk, rst          - rising-edge clock, async active-low reset
//   cmd_valid/ready   - command handshake (ready only while idle)
//   cmd_write/addr/wdata/strb - command payload
//   rsp_valid         - one-cycle completion pulse
//   rsp_rdata/err/timeout - completion result, held between pulses
//   PSEL..PWDATA      - APB requester outputs
//   PRDATA/PREADY/PSLVERR - APB completer inputs
module apb_requester #(
  parameter int PADDR_SIZE     = 32,
  parameter int PDATA_SIZE     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [PADDR_SIZE-1:0]   cmd_addr,
  input  logic [PDATA_SIZE-1:0]   cmd_wdata,
  input  logic [PDATA_SIZE/8-1:0] cmd_strb,

  output logic                    rsp_valid,
  output logic [PDATA_SIZE-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,

  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic                    PWRITE,
  output logic [PDATA_SIZE/8-1:0] PSTRB,
  output logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int SW = PDATA_SIZE / 8;

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  // Counter value seen during the last allowed ACCESS cycle.
  localparam logic [CW-1:0] TO_LAST =
    TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

  state_e                state_q, state_d;
  logic [PADDR_SIZE-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [SW-1:0]         pstrb_q, pstrb_d;
  logic [PDATA_SIZE-1:0] pwdata_q, pwdata_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [PDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_to_q, rsp_to_d;

  logic                  to_hit;

  // Limit reached on this edge; PREADY still takes priority.
  assign to_hit = TO_EN && (cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pstrb_d     = pstrb_q;
    pwdata_d    = pwdata_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_to_d    = rsp_to_q;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwrite_d = cmd_write;
          pstrb_d  = cmd_write ? cmd_strb  : '0;
          pwdata_d = cmd_write ? cmd_wdata : '0;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : PRDATA;
          rsp_err_d   = PSLVERR;
          rsp_to_d    = 1'b0;
          state_d     = IDLE;
        end else if (to_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          rsp_to_d    = 1'b1;
          state_d     = IDLE;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pstrb_q     <= '0;
      pwdata_q    <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_to_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pstrb_q     <= pstrb_d;
      pwdata_q    <= pwdata_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_to_q    <= rsp_to_d;
    end
  end

  // Bus strobes decode straight from the state register, so an
  // asynchronous reset drops them without waiting for a clock.
  assign cmd_ready   = (state_q == IDLE);
  assign PSEL        = (state_q != IDLE);
  assign PENABLE     = (state_q == ACCESS);
  assign PADDR       = paddr_q;
  assign PWRITE      = pwrite_q;
  assign PSTRB       = pstrb_q;
  assign PWDATA      = pwdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_to_q;

endmodule
